seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative unsigned restoring divider. It computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- It is the inverse arithmetic counterpart of the combinational add/sub datapath. Each trial subtraction is built from the same fulladder ripple chain with the subtract mode tied high (b inverted, carry-in = 1).
- It sits beside the ALU datapath and is driven by a start/done handshake from the control unit.

Parameters:
- WIDTH, 5, bit width of dividend, divisor, quotient and remainder.
- CW, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk_i  input  1  system clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request a division. Sampled only in IDLE.
- dividend_i  input  WIDTH  unsigned dividend. Captured on the accepted start.
- divisor_i  input  WIDTH  unsigned divisor. Captured on the accepted start.
- quotient_o  output  WIDTH  registered quotient. Held until the next accepted start.
- remainder_o  output  WIDTH  registered remainder. Held until the next accepted start.
- busy_o  output  1  high while in CALC.
- done_o  output  1  one-cycle pulse: result valid.
- dbz_o  output  1  divide-by-zero flag for the current result. Held with the result.

Behaviour:
- Reset (rst_ni low, asynchronous): state goes to IDLE. quotient_o, remainder_o, busy_o, done_o and dbz_o all go to 0, as do the counter and internal registers.
- Reset asserted mid-operation aborts the division. No done_o is issued.
- States and transitions:
  - IDLE, then CALC when start_i=1 and the divisor is nonzero.
  - IDLE, then DONE when start_i=1 and divisor_i=0.
  - CALC, then DONE after WIDTH iterations.
  - DONE, then IDLE unconditionally.
- Accept (edge E0, state IDLE, start_i=1):
  - Latch Q := dividend_i, D := divisor_i, R := 0 (WIDTH+1 bits), counter := 0.
  - Clear dbz_o.
- CALC, each edge E1..EWIDTH:
  - Form {R,Q} shifted left by 1.
  - Compute T = R_shifted - {0,D} on a (WIDTH+1)-bit fulladder chain.
  - If the chain carry-out is 1 (no borrow): R := T and the new Q LSB := 1.
  - Otherwise: R := R_shifted and the new Q LSB := 0.
  - counter increments.
  - At EWIDTH: quotient_o := Q, remainder_o := R[WIDTH-1:0], state goes to DONE.
- busy_o is 1 in CALC only. It is 1 for exactly WIDTH cycles, starting after E0.
- done_o is 1 in DONE only. It is exactly one cycle wide, in the cycle after EWIDTH, which is WIDTH+1 edges after E0.
- Divide by zero: on the E0 edge, quotient_o := all ones, remainder_o := dividend_i, and dbz_o := 1. done_o is then high in the cycle after E0, so latency is 1.
- Outputs stay stable during CALC. quotient_o and remainder_o keep the previous result and update only on the final edge.
- start_i while in CALC or DONE is ignored. There is no queueing.
- A start_i held high continuously produces back-to-back divisions with one IDLE cycle between them.
- Operand inputs may change freely after E0 without effect.
- Result invariant for a nonzero divisor: dividend = quotient*divisor + remainder, with remainder < divisor.
- Edge cases: dividend 0 gives q=0, r=0. Divisor 1 gives q=dividend, r=0. Dividend < divisor gives q=0, r=dividend.

Test Plan:
- 23 / 5 (WIDTH=5): start pulse at E0 → busy_o high for 5 cycles, done_o pulse in the cycle after E5, quotient_o=4, remainder_o=3, dbz_o=0.
- 31 / 1 → q=31, r=0. Then 7 / 9 → q=0, r=7. Then 0 / 3 → q=0, r=0. Each takes 6 cycles from start to done.
- 17 / 0 → done_o in the cycle after E0, quotient_o=31, remainder_o=17, dbz_o=1, busy_o never high. A following 10 / 3 clears dbz_o and gives q=3, r=1.
- start_i pulsed with 12/4 at cycle 2 of an ongoing 29/6 → 29/6 completes with q=4, r=5, and no second done_o follows.
- rst_ni driven low asynchronously mid-CALC (between clock edges) → all outputs read 0 immediately and no done_o appears. After release, 25/7 gives q=3, r=4.
- Exhaustive sweep of all 32x31 nonzero-divisor pairs with start held high → every result matches the reference model. Back-to-back spacing is 7 cycles between done_o pulses.

Source files
------------

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between the control unit and seq_divider.
// clk_i and rst_ni are kept off this bus and remain plain module ports.
interface seq_divider_if #(
  parameter int WIDTH = 5
);
  logic             start_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             busy_o;
  logic             done_o;
  logic             dbz_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  quotient_o, remainder_o, busy_o, done_o, dbz_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output quotient_o, remainder_o, busy_o, done_o, dbz_o
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, each trial
// subtraction done on a fulladder ripple chain in subtract mode.
module seq_divider #(
  parameter int WIDTH = 5,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic        clk_i,
  input logic        rst_ni,
  seq_divider_if.slave bus
);

  localparam logic [1:0]    IDLE     = 2'd0;
  localparam logic [1:0]    CALC     = 2'd1;
  localparam logic [1:0]    DONE     = 2'd2;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] chain_s;
  logic [WIDTH:0]   r_next_s;
  logic [WIDTH-1:0] q_next_s;

  // a - b as a + ~b + 1 on a ripple of full adders; MSB of the result is the carry-out (1 = no borrow)
  function automatic logic [WIDTH+1:0] sub_chain(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [WIDTH:0] bn;
    logic [WIDTH:0] s;
    logic           c;
    bn = ~b;
    c  = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      s[i] = a[i] ^ bn[i] ^ c;
      c    = (a[i] & bn[i]) | (c & (a[i] ^ bn[i]));
    end
    return {c, s};
  endfunction

  // One restoring step: shift {R,Q}, trial subtract, keep or restore
  always_comb begin
    shifted_s = (r_r << 1) | {{WIDTH{1'b0}}, q_r[WIDTH-1]};
    chain_s   = sub_chain(shifted_s, {1'b0, d_r});
    if (chain_s[WIDTH+1]) begin
      r_next_s = chain_s[WIDTH:0];
      q_next_s = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      r_next_s = shifted_s;
      q_next_s = {q_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, working registers and registered result outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      r_r         <= {(WIDTH+1){1'b0}};
      cnt_r       <= CNT_ZERO;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (bus.start_i) begin
            q_r   <= bus.dividend_i;
            d_r   <= bus.divisor_i;
            r_r   <= {(WIDTH+1){1'b0}};
            cnt_r <= CNT_ZERO;
            dbz_r <= (bus.divisor_i == {WIDTH{1'b0}});
            if (bus.divisor_i == {WIDTH{1'b0}}) begin
              // divide by zero resolves on the accept edge itself
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= bus.dividend_i;
              done_r      <= 1'b1;
              state_r     <= DONE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          q_r   <= q_next_s;
          r_r   <= r_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            quotient_r  <= q_next_s;
            remainder_r <= r_next_s[WIDTH-1:0];
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient_o  = quotient_r;
  assign bus.remainder_o = remainder_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;
  assign bus.dbz_o       = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=5) with hand-computed expectations
// and an exhaustive back-to-back sweep.
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  seq_divider_if #(.WIDTH(5)) bus ();

  seq_divider #(.WIDTH(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one division from an IDLE negedge; returns edges from E0 to done and busy cycles seen.
  // Leaves the bench on the negedge after done, with the DUT back in IDLE.
  task automatic run_div(input logic [4:0] a, input logic [4:0] b, output int lat, output int busy_cnt);
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    @(posedge clk);
    lat      = 1;
    busy_cnt = 0;
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.dividend_i = ~a;
    bus.divisor_i  = ~b;
    while (bus.done_o !== 1'b1 && lat < 20) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.dividend_i = 5'd0;
    bus.divisor_i  = 5'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.quotient_o, bus.remainder_o, bus.busy_o, bus.done_o, bus.dbz_o} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b required all zero",
               bus.quotient_o, bus.remainder_o, bus.busy_o, bus.done_o, bus.dbz_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int bc;
    run_div(5'd23, 5'd5, lat, bc);
    total++;
    if (lat != 6) begin bad++; $display("FAIL basic_latency: got %0d required 6", lat); end
    total++;
    if (bc != 5) begin bad++; $display("FAIL basic_busy_cycles: got %0d required 5", bc); end
    total++;
    if (bus.quotient_o !== 5'd4 || bus.remainder_o !== 5'd3 || bus.dbz_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_23_5: got q=%0d r=%0d dbz=%b required q=4 r=3 dbz=0",
               bus.quotient_o, bus.remainder_o, bus.dbz_o);
    end
    total++;
    if (bus.done_o !== 1'b0) begin bad++; $display("FAIL basic_done_width: got done=%b required 0", bus.done_o); end
  endtask

  task automatic test_edge_cases();
    logic [4:0] a_t [3] = '{5'd31, 5'd7, 5'd0};
    logic [4:0] b_t [3] = '{5'd1,  5'd9, 5'd3};
    logic [4:0] q_t [3] = '{5'd31, 5'd0, 5'd0};
    logic [4:0] r_t [3] = '{5'd0,  5'd7, 5'd0};
    int lat;
    int bc;
    for (int i = 0; i < 3; i++) begin
      run_div(a_t[i], b_t[i], lat, bc);
      total++;
      if (lat != 6 || bus.quotient_o !== q_t[i] || bus.remainder_o !== r_t[i]) begin
        bad++;
        $display("FAIL edge_%0d_%0d: got q=%0d r=%0d lat=%0d required q=%0d r=%0d lat=6",
                 a_t[i], b_t[i], bus.quotient_o, bus.remainder_o, lat, q_t[i], r_t[i]);
      end
    end
  endtask

  task automatic test_dbz();
    int lat;
    int bc;
    run_div(5'd17, 5'd0, lat, bc);
    total++;
    if (lat != 1 || bc != 0) begin
      bad++;
      $display("FAIL dbz_timing: got lat=%0d busy=%0d required lat=1 busy=0", lat, bc);
    end
    total++;
    if (bus.quotient_o !== 5'd31 || bus.remainder_o !== 5'd17 || bus.dbz_o !== 1'b1) begin
      bad++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b required q=31 r=17 dbz=1",
               bus.quotient_o, bus.remainder_o, bus.dbz_o);
    end
    run_div(5'd10, 5'd3, lat, bc);
    total++;
    if (bus.quotient_o !== 5'd3 || bus.remainder_o !== 5'd1 || bus.dbz_o !== 1'b0 || lat != 6) begin
      bad++;
      $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b lat=%0d required q=3 r=1 dbz=0 lat=6",
               bus.quotient_o, bus.remainder_o, bus.dbz_o, lat);
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int waited;
    bus.dividend_i = 5'd29;
    bus.divisor_i  = 5'd6;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.quotient_o !== 5'd3 || bus.remainder_o !== 5'd1) begin
      bad++;
      $display("FAIL hold_during_calc: got q=%0d r=%0d required q=3 r=1", bus.quotient_o, bus.remainder_o);
    end
    bus.dividend_i = 5'd12;
    bus.divisor_i  = 5'd4;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    waited = 0;
    while (bus.done_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (bus.quotient_o !== 5'd4 || bus.remainder_o !== 5'd5 || waited != 3) begin
      bad++;
      $display("FAIL ignore_start_result: got q=%0d r=%0d wait=%0d required q=4 r=5 wait=3",
               bus.quotient_o, bus.remainder_o, waited);
    end
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) n_done++;
    end
    total++;
    if (n_done != 0) begin bad++; $display("FAIL ignore_start_extra_done: got %0d pulses required 0", n_done); end
  endtask

  task automatic test_async_reset();
    int n_done;
    int lat;
    int bc;
    bus.dividend_i = 5'd23;
    bus.divisor_i  = 5'd5;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.quotient_o, bus.remainder_o, bus.busy_o, bus.done_o, bus.dbz_o} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b required all zero",
               bus.quotient_o, bus.remainder_o, bus.busy_o, bus.done_o, bus.dbz_o);
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) n_done++;
    end
    total++;
    if (n_done != 0) begin bad++; $display("FAIL async_reset_abort: got %0d active cycles required 0", n_done); end
    run_div(5'd25, 5'd7, lat, bc);
    total++;
    if (bus.quotient_o !== 5'd3 || bus.remainder_o !== 5'd4 || lat != 6) begin
      bad++;
      $display("FAIL after_reset_25_7: got q=%0d r=%0d lat=%0d required q=3 r=4 lat=6",
               bus.quotient_o, bus.remainder_o, lat);
    end
  endtask

  task automatic test_back_to_back();
    int prev_cyc;
    int waited;
    logic [4:0] eq;
    logic [4:0] er;
    prev_cyc    = -1;
    bus.start_i = 1'b1;
    for (int a = 0; a < 32; a++) begin
      for (int b = 1; b < 32; b++) begin
        bus.dividend_i = a[4:0];
        bus.divisor_i  = b[4:0];
        eq = 5'(a / b);
        er = 5'(a % b);
        @(posedge clk);
        waited = 1;
        @(negedge clk);
        bus.dividend_i = 5'd0;
        bus.divisor_i  = 5'd0;
        while (bus.done_o !== 1'b1 && waited < 20) begin
          @(negedge clk);
          waited++;
        end
        total++;
        if (bus.quotient_o !== eq || bus.remainder_o !== er || bus.dbz_o !== 1'b0 || waited != 6) begin
          bad++;
          $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d required q=%0d r=%0d dbz=0 lat=6",
                   a, b, bus.quotient_o, bus.remainder_o, bus.dbz_o, waited, eq, er);
        end
        if (prev_cyc >= 0) begin
          total++;
          if (cyc - prev_cyc != 7) begin
            bad++;
            $display("FAIL sweep_spacing_%0d_%0d: got %0d cycles required 7", a, b, cyc - prev_cyc);
          end
        end
        prev_cyc = cyc;
        @(negedge clk);
      end
    end
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_basic();
    test_edge_cases();
    test_dbz();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
